// File: rtl/compare_ctrl.sv
// Sequencer for a serial 32-bit magnitude comparator: accept a pair, run the
// comparator with a timeout, and hold the captured result until it is consumed.
module compare_ctrl #(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  output logic [31:0]   cmp_a,
  output logic [31:0]   cmp_b,
  output logic          cmp_start,
  output logic          cmp_rst,
  input  logic          cmp_done,
  input  logic          cmp_l,
  input  logic          cmp_e,
  input  logic          cmp_g,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_l,
  output logic          out_e,
  output logic          out_g,
  output logic          out_err,
  output logic [CW-1:0] done_cnt
);

  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [3:0]    res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          onehot;

  assign onehot = ( cmp_l & ~cmp_e & ~cmp_g) |
                  (~cmp_l &  cmp_e & ~cmp_g) |
                  (~cmp_l & ~cmp_e &  cmp_g);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      wait_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wait_q  <= wait_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    wait_d  = wait_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = LOAD;
        end
      end
      LOAD: begin
        wait_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        wait_d = wait_q + 1'b1;
        // done wins over a timeout landing on the same cycle
        if (cmp_done) begin
          res_d   = {cmp_l, cmp_e, cmp_g, ~onehot};
          state_d = HOLD;
        end else if (wait_q == WLAST) begin
          res_d   = 4'b0001;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          cnt_d   = cnt_q + 1'b1;
          res_d   = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  // comparator is kept in reset whenever it is not running
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign cmp_rst   = (state_q != RUN);
  assign cmp_start = (state_q == LOAD) ||
                     ((state_q == RUN) && (wait_q == '0));
  assign cmp_a     = a_q;
  assign cmp_b     = b_q;
  assign {out_l, out_e, out_g, out_err} = res_q;
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_compare_ctrl.sv
// Directed bench for compare_ctrl with a behavioural serial comparator
// whose done latency and flag values are set per transaction.
module tb_compare_ctrl;

  localparam int TO = 40;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   in_a = '0;
  logic [31:0]   in_b = '0;
  logic          in_ready;
  logic [31:0]   cmp_a, cmp_b;
  logic          cmp_start, cmp_rst;
  logic          cmp_done, cmp_l, cmp_e, cmp_g;
  logic          out_valid, out_l, out_e, out_g, out_err;
  logic [CW-1:0] done_cnt;

  int            model_n = 0;
  bit            mforce = 1'b0;
  logic          f_l = 1'b0, f_e = 1'b0, f_g = 1'b0;
  int            mcnt = 0;

  int            n_chk = 0;
  int            n_pass = 0;
  logic [CW-1:0] cnt_exp = '0;

  compare_ctrl #(.TIMEOUT(TO), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_start (cmp_start),
    .cmp_rst   (cmp_rst),
    .cmp_done  (cmp_done),
    .cmp_l     (cmp_l),
    .cmp_e     (cmp_e),
    .cmp_g     (cmp_g),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_l     (out_l),
    .out_e     (out_e),
    .out_g     (out_g),
    .out_err   (out_err),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  // comparator model: done during its model_n-th cycle out of reset
  always_ff @(posedge clk) begin
    if (cmp_rst) mcnt <= 0;
    else         mcnt <= mcnt + 1;
  end

  assign cmp_done = (model_n != 0) && !cmp_rst && (mcnt == model_n - 1);
  assign cmp_l = mforce ? f_l : (cmp_a <  cmp_b);
  assign cmp_e = mforce ? f_e : (cmp_a == cmp_b);
  assign cmp_g = mforce ? f_g : (cmp_a >  cmp_b);

  function automatic logic [31:0] flags();
    return 32'({out_l, out_e, out_g, out_err});
  endfunction

  function automatic logic [31:0] strb();
    return 32'({cmp_start, cmp_rst});
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] b,
                     input int n, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    model_n  = n;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    chk("load_strb", strb(), 32'd3);
    chk("cmp_a", cmp_a, a);
    chk("cmp_b", cmp_b, b);
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2) chk("run1_strb", strb(), 32'd2);
      else if (!out_valid) chk("runk_strb", strb(), 32'd0);
    end
  endtask

  task automatic ack(input int hold);
    logic [31:0] f0, a0;
    f0 = flags();
    a0 = cmp_a;
    if (hold > 0) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 32'h1234;
      in_b     = 32'h5678;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_flags", flags(), f0);
      chk("hold_cnt", 32'(done_cnt), 32'(cnt_exp));
      chk("hold_a", cmp_a, a0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    cnt_exp   = cnt_exp + 1'b1;
    chk("ack_valid", 32'(out_valid), 32'd0);
    chk("ack_flags", flags(), 32'd0);
    chk("ack_cnt", 32'(done_cnt), 32'(cnt_exp));
    chk("ack_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    #2 rst = 1'b0;
    #10;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_a", cmp_a, 32'd0);
    chk("rst_b", cmp_b, 32'd0);
    chk("rst_strb", strb(), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", flags(), 32'd0);
    chk("rst_cnt", 32'(done_cnt), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    txn(32'h5, 32'h3, 32, lat);
    chk("gt_lat", 32'(lat), 32'd34);
    chk("gt_flags", flags(), 32'b0010);
    chk("gt_cnt", 32'(done_cnt), 32'd0);
    ack(0);

    txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, lat);
    chk("eq_lat", 32'(lat), 32'd7);
    chk("eq_flags", flags(), 32'b0100);
    ack(10);

    txn(32'h7, 32'h9, 0, lat);
    chk("to_lat", 32'(lat), 32'(TO + 2));
    chk("to_flags", flags(), 32'b0001);
    ack(0);

    txn(32'h1, 32'h2, TO, lat);
    chk("tie_lat", 32'(lat), 32'(TO + 2));
    chk("tie_flags", flags(), 32'b1000);
    ack(0);

    txn(32'h9, 32'h2, TO + 1, lat);
    chk("late_lat", 32'(lat), 32'(TO + 2));
    chk("late_flags", flags(), 32'b0001);
    ack(0);

    mforce = 1'b1;
    f_l = 1'b1;
    f_e = 1'b0;
    f_g = 1'b1;
    txn(32'h4, 32'h4, 3, lat);
    chk("bad_lat", 32'(lat), 32'd5);
    chk("bad_flags", flags(), 32'b1011);
    ack(0);
    mforce = 1'b0;

    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 32'hAA;
    in_b     = 32'hBB;
    model_n  = 32;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_a", cmp_a, 32'd0);
    chk("abort_strb", strb(), 32'd1);
    chk("abort_flags", flags(), 32'd0);
    chk("abort_cnt", 32'(done_cnt), 32'd0);
    cnt_exp = '0;
    @(negedge clk);
    rst = 1'b1;

    txn(32'h3, 32'h7, 4, lat);
    chk("lt_lat", 32'(lat), 32'd6);
    chk("lt_flags", flags(), 32'b1000);
    ack(0);

    for (int i = 0; i < 254; i++) begin
      txn(32'(i), 32'(i), 1, lat);
      ack(0);
    end
    chk("cnt_max", 32'(done_cnt), 32'hFF);
    txn(32'h1, 32'h1, 2, lat);
    chk("wrap_lat", 32'(lat), 32'd4);
    ack(0);
    chk("wrap_cnt", 32'(done_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/compare_ctrl.md
COMPARE_CTRL -- requirements
Module: compare_ctrl

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 40: maximum RUN-state cycles to wait for cmp_done.
REQ-002 The module SHALL have parameter CW, default 16: width of the completed-comparison counter.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream operand pair is valid.
REQ-006 in_ready  output  1  high only in IDLE; a pair SHALL be accepted on posedge when in_valid and in_ready are both high.
REQ-007 in_a, in_b  input  32 each  unsigned operands.
REQ-008 cmp_a, cmp_b  output  32 each  operands driven to the serial comparator.
REQ-009 cmp_start  output  1  comparator load strobe.
REQ-010 cmp_rst  output  1  active-high reset to the comparator.
REQ-011 cmp_done, cmp_l, cmp_e, cmp_g  input  1 each  comparator done flag and less, equal and greater flags.
REQ-012 out_valid  output  1  result valid to downstream.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_l, out_e, out_g, out_err  output  1 each  captured result and error flag.
REQ-015 done_cnt  output  CW  number of results handed downstream.

Function
REQ-016 The FSM SHALL have exactly four states, IDLE, LOAD, RUN and HOLD, encoded in 2 bits.
REQ-017 IDLE: in_ready=1; on acceptance the block SHALL register in_a and in_b into cmp_a and cmp_b and go to LOAD.
REQ-018 LOAD (exactly 1 cycle): the block SHALL assert cmp_rst=1 and cmp_start=1, clear the wait counter, and go to RUN.
REQ-019 RUN: cmp_start SHALL be held 1 for the first RUN cycle only and cmp_rst SHALL be 0; the wait counter SHALL increment every cycle.
REQ-020 RUN, when cmp_done=1 is sampled: the block SHALL capture cmp_l, cmp_e and cmp_g into out_l, out_e and out_g and go to HOLD.
REQ-021 At capture, out_err SHALL be set to 1 if the captured flags are not exactly one-hot; the captured flags SHALL still be presented as sampled.
REQ-022 RUN, when the wait counter reaches TIMEOUT without cmp_done: the block SHALL go to HOLD with out_l=out_e=out_g=0 and out_err=1.
REQ-023 If cmp_done and the timeout occur in the same cycle, cmp_done SHALL take priority (normal capture, no timeout error).
REQ-024 cmp_a and cmp_b SHALL stay stable from LOAD until HOLD is exited.
REQ-025 HOLD: out_valid SHALL be 1 and the result outputs SHALL be stable until out_ready=1 is sampled.
REQ-026 On the HOLD handshake the block SHALL increment done_cnt, return to IDLE and drop out_valid on the next cycle; there SHALL be no back-to-back bypass.
REQ-027 done_cnt SHALL wrap from all-ones to 0 with no flag.
REQ-028 Accept-to-out_valid latency SHALL be 2 + N cycles, where N is the number of RUN cycles up to and including the cmp_done sample.
REQ-029 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside HOLD.
REQ-030 Result flags SHALL be 0 whenever out_valid=0.

Reset
REQ-031 While rst=0 the block SHALL be in IDLE with in_ready=1, cmp_a=cmp_b=0, cmp_start=0, cmp_rst=1, out_valid=0, out_l=out_e=out_g=out_err=0 and done_cnt=0.
REQ-032 Reset asserted mid-RUN or mid-HOLD SHALL abort the operation immediately (asynchronously) with no output; done_cnt SHALL NOT increment.
REQ-033 The first acceptance SHALL be possible on the first posedge after rst rises.

Verification
REQ-034 Accept A=0x0000_0005, B=0x0000_0003 with a comparator model giving done after 32 RUN cycles -> out_g=1, out_l=out_e=out_err=0, out_valid at acceptance+34 cycles, done_cnt=1.
REQ-035 Accept A=B=0xFFFF_FFFF with out_ready held 0 for 10 cycles -> out_e=1 and out_valid stable for all 10 cycles, done_cnt increments only on handshake.
REQ-036 Model never asserts cmp_done -> out_err=1, all flags 0, out_valid after TIMEOUT RUN cycles.
REQ-037 Model returns l=1, g=1 with done -> out_l=1, out_g=1, out_err=1.
REQ-038 rst=0 pulse at RUN cycle 10 -> outputs return to reset values immediately, done_cnt=0, and the next pair completes normally.
REQ-039 Preload done_cnt to 0xFFFF via 65535 transactions (or a forced value) and complete one more -> done_cnt=0x0000.
